// File: rtl/bcd_scan_pkg.sv
//------------------------------------------------------------------------------
// bcd_scan_pkg : BCD digit type and active-low 7-segment patterns {dp,g..a}
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal codes cannot occur but still map to a dark digit.
  function automatic logic [7:0] seg_decode(input bcd_t v);
    case (v)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
//------------------------------------------------------------------------------
// bcd_digit : single BCD digit register, steps +/-1 mod 10 with carry/borrow out
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit
  import bcd_scan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic up,
  input  logic carry_in,
  output bcd_t digit,
  output logic carry_out
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic at_limit;

  always_comb begin
    at_limit  = up ? (digit_q == 4'd9) : (digit_q == 4'd0);
    carry_out = step & carry_in & at_limit;
    digit_d   = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (step && carry_in) begin
      if (up) digit_d = at_limit ? 4'd0 : digit_q + 4'd1;
      else    digit_d = at_limit ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
//------------------------------------------------------------------------------
// bcd_scan_counter : N-digit BCD tick counter with multiplexed 7-segment drive.
//                    Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 12_500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    up,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
  logic [7:0]            seg_data_q, seg_data_d;

  logic                  tick;
  logic                  chained;
  logic [NUM_DIGITS-1:0] carry_in;
  logic [NUM_DIGITS-1:0] carry_out;
  bcd_t                  digit_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] show;
  bcd_t                  cur_digit;
  logic                  cur_show;

  // A tick landing on a clear cycle is dropped rather than deferred.
  assign tick    = (tick_cnt_q == c_tick_last) && !clear;
  assign chained = &dig_en_n;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_first
        assign carry_in[i] = chained ? 1'b1 : ~dig_en_n[i];
      end else begin : g_rest
        assign carry_in[i] = chained ? carry_out[i-1] : ~dig_en_n[i];
      end

      bcd_digit u_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .step      (tick),
        .up        (up),
        .carry_in  (carry_in[i]),
        .digit     (digit_val[i]),
        .carry_out (carry_out[i])
      );

      assign digits[4*i +: 4] = digit_val[i];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top down; a digit is shown once any digit at or above it is non-zero.
  always_comb begin
    logic seen;
    seen = 1'b0;
    show = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (digit_val[i] != 4'd0);
      show[i] = seen || (i == 0) || !chained;
    end
  end
`else
  assign show = '1;
`endif

  always_comb begin
    cur_digit = '0;
    cur_show  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_digit = digit_val[i];
        cur_show  = show[i];
      end
    end
  end

  always_comb begin
    tick_cnt_d = (tick_cnt_q == c_tick_last) ? '0 : tick_cnt_q + 1'b1;
    if (clear) tick_cnt_d = '0;

    wrap_d = tick & chained & carry_out[NUM_DIGITS-1];

    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == c_scan_last) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == c_idx_last) ? '0 : scan_idx_q + 1'b1;
    end

    seg_sel_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_data_d = cur_show ? seg_decode(cur_digit) : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      seg_sel_q  <= '1;
      seg_data_q <= SEG_BLANK;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
      seg_sel_q  <= seg_sel_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign wrap     = wrap_q;
  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;

endmodule

`default_nettype wire

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised N-digit BCD tick counter with multiplexed active-low 7-segment drive, for the board-level demo top. Counts once per programmable tick, either as a whole decimal number (carry/borrow chained) or as independently stepped digits selected by active-low enables. Adds up/down counting, synchronous clear and a wrap pulse. Drives the digit selects and segment bus directly.

## Interface
Parameters:
- NUM_DIGITS, 4, number of BCD digits and select lines (1..8)
- TICK_DIV, 50_000_000, clk cycles per count tick (≥2)
- SCAN_DIV, 12_500, clk cycles per display digit slot (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous clear of digits and tick timer, active-high
- up  in  1  1 = count up, 0 = count down; sampled on tick cycle
- dig_en_n  in  NUM_DIGITS  per-digit step enable, active-low; all-ones selects chained mode
- digits  out  4*NUM_DIGITS  current BCD value, digit 0 in bits [3:0]
- wrap  out  1  one-cycle pulse on whole-number wrap (chained mode only)
- seg_sel  out  NUM_DIGITS  digit select, active-low, one-cold
- seg_data  out  8  segments {dp,g..a}, active-low

## Operation
- Tick timer counts 0..TICK_DIV-1; tick asserted on cycle where timer == TICK_DIV-1, timer returns to 0.
- Chained mode (dig_en_n all ones), on tick: up: digit0+1, carry into next digit when digit == 9 (digit → 0); down: digit0−1, borrow when digit == 0 (digit → 9).
- Chained wrap: up from all-9s → all-0s, or down from all-0s → all-9s; wrap pulses on the following cycle (registered).
- Independent mode (any dig_en_n bit low), on tick: each digit with enable low steps ±1 modulo 10; no carry, no borrow, wrap never asserted.
- Priority: rst_n > clear > tick. clear zeroes digits and tick timer; a tick coinciding with clear is discarded.
- Scan: scan timer 0..SCAN_DIV-1; at SCAN_DIV-1 scan index advances, wrapping from NUM_DIGITS-1 to 0. Display runs independently of clear.
- seg_sel drives low only the bit at scan index; seg_data = pattern of digits[index]. Values 10..15 (unreachable) decode to blank 8'hFF.
- Patterns 0..9: C0 F9 A4 B0 99 92 82 F8 80 90 (hex), dp always off.

## Timing
- Reset values: digits 0, wrap 0, seg_sel all ones, seg_data 8'hFF, tick/scan timers 0, scan index 0.
- digits registered: new value visible the cycle after the tick cycle.
- wrap: asserted exactly one cycle, same cycle digits show the wrapped value.
- seg_sel/seg_data registered from scan index and digits: one-cycle latency; first digit-0 drive on cycle 1 after reset release.
- Reset mid-count or mid-scan: all state returns to reset values on the next clk edge; no partial steps.
- up and dig_en_n sampled only on tick cycle; changes between ticks have no effect.

## Configuration
- LEADING_ZERO_BLANK_EN defined: in chained mode, display blanks (8'hFF) any digit that is 0 and above the highest non-zero digit; digit 0 is never blanked. digits output unaffected. Independent mode never blanks.
- Not defined: all digits always displayed, including leading zeros.

## Structure
- Package bcd_scan_pkg: 7-seg pattern constants SEG_0..SEG_9, SEG_BLANK, and bcd_t (4-bit) typedef.
- Sub-module bcd_digit: one digit register with step, up, carry_in, carry_out (wrap 9→0 / 0→9), instantiated NUM_DIGITS times in a generate loop; chain carry_in from previous carry_out in chained mode, tie to enable in independent mode.

## Test plan
- Reset, TICK_DIV=4, dig_en_n=1111, up=1: 12 ticks → digits 0x0012; wrap never asserted.
- Preload via ticks to 0x9999, one more up tick → digits 0x0000, wrap high exactly one cycle.
- From 0x0000, up=0, one tick → 0x9999 with wrap pulse; next tick → 0x9998.
- dig_en_n=1010 from 0x0909: one up tick → 0x0000 (digits 0 and 2 wrap independently), no wrap, digits 1 and 3 unchanged.
- SCAN_DIV=2, value 0x1234: seg_sel cycles 1110,1101,1011,0111 every 2 cycles with seg_data 99,B0,A4,F9 aligned; clear coinciding with tick → 0x0000, tick lost.
- LEADING_ZERO_BLANK_EN, value 0x0040: selects 3 and 2 show FF, select 1 shows 99, select 0 shows C0.
